// File: rtl/traffic_light_pkg.sv
// Shared definitions for the traffic light controller and its monitor.
//   - light codes driven by the controller (RED, GREEN, YELLOW, ILLEGAL)
//   - monitor FSM state and per-cycle event encodings
//   - next_light(): legal successor of a phase (Red->Green->Yellow->Red)
//   - state_for_light(): monitor phase state matching a light code
package traffic_light_pkg;

  localparam logic [1:0] LIGHT_RED     = 2'd0;
  localparam logic [1:0] LIGHT_GREEN   = 2'd1;
  localparam logic [1:0] LIGHT_YELLOW  = 2'd2;
  localparam logic [1:0] LIGHT_ILLEGAL = 2'd3;

  typedef enum logic [2:0] {
    ST_INIT,
    ST_RED,
    ST_GREEN,
    ST_YELLOW,
    ST_FAULT
  } mon_state_e;

  // What the monitor decided about the current sample.
  typedef enum logic [2:0] {
    EV_NONE,     // nothing to do (INIT ignoring a code, FAULT waiting)
    EV_START,    // first Red seen in INIT
    EV_HOLD,     // same phase, dwell still below the limit
    EV_ADVANCE,  // legal phase advance
    EV_CODE,     // illegal light code
    EV_SEQ,      // skipped phase or premature advance
    EV_TIMEOUT,  // phase held past the dwell limit
    EV_CLEAR     // err_clear accepted in FAULT
  } mon_event_e;

  function automatic logic [1:0] next_light(input logic [1:0] light);
    logic [1:0] nxt;
    unique case (light)
      LIGHT_RED:    nxt = LIGHT_GREEN;
      LIGHT_GREEN:  nxt = LIGHT_YELLOW;
      LIGHT_YELLOW: nxt = LIGHT_RED;
      default:      nxt = LIGHT_RED;
    endcase
    return nxt;
  endfunction

  function automatic mon_state_e state_for_light(input logic [1:0] light);
    mon_state_e st;
    unique case (light)
      LIGHT_RED:    st = ST_RED;
      LIGHT_GREEN:  st = ST_GREEN;
      LIGHT_YELLOW: st = ST_YELLOW;
      default:      st = ST_FAULT;
    endcase
    return st;
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter for the traffic light monitor.
// Ports:
//   clock    in   rising-edge clock
//   reset    in   synchronous active-high reset (count -> 0)
//   clear    in   count -> 0
//   load_one in   count -> 1 (start of a new phase)
//   incr     in   count -> count + 1
//   count    out  current dwell count
//   at_max   out  count equals MAX_DWELL
// Priority: reset > clear > load_one > incr; otherwise the count holds.
module dwell_counter #(
  parameter int CNT_W     = 8,
  parameter int MAX_DWELL = 255
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             clear,
  input  logic             load_one,
  input  logic             incr,
  output logic [CNT_W-1:0] count,
  output logic             at_max
);

  localparam logic [CNT_W-1:0] MAX_C = CNT_W'(MAX_DWELL);

  logic [CNT_W-1:0] count_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // pre-edge values, independent of block evaluation order.
  always_ff @(posedge clock) begin
    if (reset || clear) begin
      count_q <= '0;
    end else if (load_one) begin
      count_q <= CNT_W'(1);
    end else if (incr) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

  assign count  = count_q;
  assign at_max = (count_q == MAX_C);

endmodule

// File: rtl/traffic_light_monitor.sv
// Downstream checker for the traffic light controller.
// Tracks the confirmed phase and its dwell, checks Red->Green->Yellow->Red
// ordering and the MIN_DWELL/MAX_DWELL limits, and latches sticky fault flags.
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   light_in[1:0]       controller light code (0 R, 1 G, 2 Y, 3 illegal)
//   err_clear           leave FAULT and clear the sticky flags
//   phase[1:0]          confirmed current phase
//   dwell[CNT_W-1:0]    cycles spent in the current phase
//   change              one-cycle pulse per legal advance
//   fault               high while in FAULT
//   seq_err, code_err, timeout_err   sticky error flags (first error only)
//   cycle_count[15:0]   completed Yellow->Red advances
// Build option: TL_MON_CYCLE_CNT_EN builds the cycle counter; otherwise
// cycle_count is tied to zero.
module traffic_light_monitor
  import traffic_light_pkg::*;
#(
  parameter int MIN_DWELL = 1,
  parameter int MAX_DWELL = 255,
  parameter int CNT_W     = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [1:0]       light_in,
  input  logic             err_clear,
  output logic [1:0]       phase,
  output logic [CNT_W-1:0] dwell,
  output logic             change,
  output logic             fault,
  output logic             seq_err,
  output logic             code_err,
  output logic             timeout_err,
  output logic [15:0]      cycle_count
);

  localparam logic [CNT_W-1:0] MIN_C = CNT_W'(MIN_DWELL);

  mon_state_e       state_q;
  logic [1:0]       phase_q;
  logic             change_q;
  logic             fault_q;
  logic             seq_err_q;
  logic             code_err_q;
  logic             timeout_err_q;

  logic [CNT_W-1:0] dwell_cnt;
  logic             at_max;
  logic [1:0]       next_phase;
  mon_event_e       ev;

  // Classify this cycle's sample; checks follow the required priority.
  // NOTE: every always_comb output gets a default first so no path leaves
  // it unassigned, which would otherwise infer a latch.
  always_comb begin
    ev         = EV_NONE;
    next_phase = next_light(phase_q);
    unique case (state_q)
      ST_INIT: begin
        if (light_in == LIGHT_ILLEGAL)  ev = EV_CODE;
        else if (light_in == LIGHT_RED) ev = EV_START;
      end
      ST_RED, ST_GREEN, ST_YELLOW: begin
        if (light_in == LIGHT_ILLEGAL)      ev = EV_CODE;
        else if (light_in == phase_q)       ev = at_max ? EV_TIMEOUT : EV_HOLD;
        else if (light_in == next_phase)    ev = (dwell_cnt < MIN_C) ? EV_SEQ : EV_ADVANCE;
        else                                ev = EV_SEQ;
      end
      ST_FAULT: begin
        if (err_clear) ev = EV_CLEAR;
      end
      default: ev = EV_NONE;
    endcase
  end

  dwell_counter #(
    .CNT_W    (CNT_W),
    .MAX_DWELL(MAX_DWELL)
  ) u_dwell (
    .clock   (clock),
    .reset   (reset),
    .clear   (ev == EV_CLEAR),
    .load_one((ev == EV_START) || (ev == EV_ADVANCE)),
    .incr    (ev == EV_HOLD),
    .count   (dwell_cnt),
    .at_max  (at_max)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_INIT;
      phase_q       <= LIGHT_RED;
      change_q      <= 1'b0;
      fault_q       <= 1'b0;
      seq_err_q     <= 1'b0;
      code_err_q    <= 1'b0;
      timeout_err_q <= 1'b0;
    end else begin
      change_q <= 1'b0;
      unique case (ev)
        EV_START: begin
          state_q <= ST_RED;
          phase_q <= LIGHT_RED;
        end
        EV_ADVANCE: begin
          state_q  <= state_for_light(next_phase);
          phase_q  <= next_phase;
          change_q <= 1'b1;
        end
        EV_CODE: begin
          state_q    <= ST_FAULT;
          fault_q    <= 1'b1;
          code_err_q <= 1'b1;
        end
        EV_SEQ: begin
          state_q   <= ST_FAULT;
          fault_q   <= 1'b1;
          seq_err_q <= 1'b1;
        end
        EV_TIMEOUT: begin
          state_q       <= ST_FAULT;
          fault_q       <= 1'b1;
          timeout_err_q <= 1'b1;
        end
        EV_CLEAR: begin
          state_q       <= ST_INIT;
          phase_q       <= LIGHT_RED;
          fault_q       <= 1'b0;
          seq_err_q     <= 1'b0;
          code_err_q    <= 1'b0;
          timeout_err_q <= 1'b0;
        end
        default: ;  // EV_NONE, EV_HOLD: phase and flags hold
      endcase
    end
  end

`ifdef TL_MON_CYCLE_CNT_EN
  logic [15:0] cycle_count_q;

  // Counts completed cycles (Yellow->Red); survives err_clear, not reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cycle_count_q <= '0;
    end else if ((ev == EV_ADVANCE) && (next_phase == LIGHT_RED)) begin
      cycle_count_q <= cycle_count_q + 16'd1;
    end
  end

  assign cycle_count = cycle_count_q;
`else
  assign cycle_count = '0;
`endif

  assign phase       = phase_q;
  assign dwell       = dwell_cnt;
  assign change      = change_q;
  assign fault       = fault_q;
  assign seq_err     = seq_err_q;
  assign code_err    = code_err_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// Self-checking bench for traffic_light_monitor.
// Two instances share the stimulus: dut_a (MIN=1, MAX=255) and
// dut_b (MIN=3, MAX=4). Each is compared every cycle against its own
// behavioural model of the phase/dwell/flag rules.
module tb_traffic_light_monitor;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  light_in = 2'd0;
  logic        err_clear = 1'b0;

  logic [1:0]  a_phase, b_phase;
  logic [7:0]  a_dwell, b_dwell;
  logic        a_change, b_change, a_fault, b_fault;
  logic        a_seq, b_seq, a_code, b_code, a_tmo, b_tmo;
  logic [15:0] a_cyc, b_cyc;

  int n_checks = 0;
  int n_fails  = 0;

  always #5 clock = ~clock;

  traffic_light_monitor #(.MIN_DWELL(1), .MAX_DWELL(255), .CNT_W(8)) dut_a (
    .clock(clock), .reset(reset), .light_in(light_in), .err_clear(err_clear),
    .phase(a_phase), .dwell(a_dwell), .change(a_change), .fault(a_fault),
    .seq_err(a_seq), .code_err(a_code), .timeout_err(a_tmo), .cycle_count(a_cyc)
  );

  traffic_light_monitor #(.MIN_DWELL(3), .MAX_DWELL(4), .CNT_W(8)) dut_b (
    .clock(clock), .reset(reset), .light_in(light_in), .err_clear(err_clear),
    .phase(b_phase), .dwell(b_dwell), .change(b_change), .fault(b_fault),
    .seq_err(b_seq), .code_err(b_code), .timeout_err(b_tmo), .cycle_count(b_cyc)
  );

  // Reference model: "started" means a Red has been accepted since reset/clear.
  typedef struct packed {
    bit started;
    bit faulted;
    bit chg;
    bit se;
    bit ce;
    bit te;
    int ph;
    int dw;
    int cyc;
  } mdl_t;

  mdl_t ma, mb;

  function automatic mdl_t model_next(mdl_t m, int l, bit clr, int min_d, int max_d);
    mdl_t r = m;
    r.chg = 0;
    if (m.faulted) begin
      if (clr) begin
        r = '0;
        r.cyc = m.cyc;
      end
    end else if (!m.started) begin
      if (l == 3) begin
        r.ce = 1; r.faulted = 1;
      end else if (l == 0) begin
        r.started = 1; r.ph = 0; r.dw = 1;
      end
    end else if (l == 3) begin
      r.ce = 1; r.faulted = 1;
    end else if (l == m.ph) begin
      if (m.dw < max_d) r.dw = m.dw + 1;
      else begin r.te = 1; r.faulted = 1; end
    end else if (l == (m.ph + 1) % 3) begin
      if (m.dw < min_d) begin
        r.se = 1; r.faulted = 1;
      end else begin
        r.ph = l; r.dw = 1; r.chg = 1;
        if (l == 0) r.cyc = (m.cyc + 1) % 65536;
      end
    end else begin
      r.se = 1; r.faulted = 1;
    end
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic compare(input string who, input mdl_t m,
                         input logic [1:0] ph, input logic [7:0] dw,
                         input logic chg, input logic flt, input logic se,
                         input logic ce, input logic te, input logic [15:0] cyc);
    int exp_cyc;
`ifdef TL_MON_CYCLE_CNT_EN
    exp_cyc = m.cyc;
`else
    exp_cyc = 0;
`endif
    check({who, ".phase"},       32'(ph),  m.ph);
    check({who, ".dwell"},       32'(dw),  m.dw);
    check({who, ".change"},      32'(chg), 32'(m.chg));
    check({who, ".fault"},       32'(flt), 32'(m.faulted));
    check({who, ".seq_err"},     32'(se),  32'(m.se));
    check({who, ".code_err"},    32'(ce),  32'(m.ce));
    check({who, ".timeout_err"}, 32'(te),  32'(m.te));
    check({who, ".cycle_count"}, 32'(cyc), exp_cyc);
  endtask

  // One clock: drive on the falling edge, update models at the rising edge,
  // compare 1 time unit later.
  task automatic step(input int l, input bit clr, input bit rst);
    @(negedge clock);
    light_in  = 2'(l);
    err_clear = clr;
    reset     = rst;
    @(posedge clock);
    if (rst) begin
      ma = '0;
      mb = '0;
    end else begin
      ma = model_next(ma, l, clr, 1, 255);
      mb = model_next(mb, l, clr, 3, 4);
    end
    #1;
    compare("a", ma, a_phase, a_dwell, a_change, a_fault, a_seq, a_code, a_tmo, a_cyc);
    compare("b", mb, b_phase, b_dwell, b_change, b_fault, b_seq, b_code, b_tmo, b_cyc);
  endtask

  initial begin
    int gen;
    int roll;
    int l;
    int seq0 [7] = '{0, 1, 2, 0, 1, 2, 0};
    ma = '0;
    mb = '0;

    // Reset state.
    step(0, 0, 1);
    step(0, 0, 1);

    // One code per cycle: dut_a advances every cycle, dut_b trips MIN_DWELL.
    foreach (seq0[i]) step(seq0[i], 0, 0);
    step(0, 0, 0);  // Red held: change drops, dwell 2

    // Red x2 then Green; then illegal codes must not add code_err to a seq fault.
    step(0, 0, 1);
    step(0, 0, 0); step(0, 0, 0); step(1, 0, 0);
    step(3, 0, 0); step(3, 0, 0);
    // err_clear, then a Red is accepted without a change pulse.
    step(3, 1, 0);
    step(2, 0, 0);
    step(0, 0, 0);

    // Skip Green from Red.
    step(0, 0, 1);
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(2, 0, 0); step(3, 0, 0);

    // dut_b timeout: Red x5; then Red x4 + Green is a legal advance at MAX.
    step(0, 0, 1);
    for (int i = 0; i < 5; i++) step(0, 0, 0);
    step(0, 0, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0);
    step(1, 0, 0);

    // Code 3 while in Green; clear, with simultaneous-error case outside FAULT.
    step(0, 0, 1);
    step(0, 0, 0); step(1, 1, 0); step(3, 1, 0); step(3, 1, 0); step(0, 0, 0);

    // dut_a timeout at dwell 255.
    step(0, 0, 1);
    for (int i = 0; i < 256; i++) step(0, 0, 0);

    // Five full cycles, stop in Green, then reset mid-phase.
    step(0, 0, 1);
    for (int c = 0; c < 5; c++) begin
      step(0, 0, 0); step(0, 0, 0); step(0, 0, 0);
      step(1, 0, 0); step(1, 0, 0); step(1, 0, 0);
      step(2, 0, 0); step(2, 0, 0); step(2, 0, 0);
    end
    step(0, 0, 0); step(0, 0, 0); step(0, 0, 0); step(1, 0, 0);
    step(1, 0, 1);
    step(1, 0, 0);

    // Random traffic: mostly holds and legal advances, some faults/clears/resets.
    gen = 0;
    for (int i = 0; i < 3000; i++) begin
      roll = int'($urandom_range(0, 99));
      if (roll < 70) begin
        l = gen;
      end else if (roll < 94) begin
        gen = (gen + 1) % 3;
        l = gen;
      end else begin
        l = int'($urandom_range(0, 3));
      end
      step(l, ($urandom_range(0, 99) < 4), ($urandom_range(0, 999) < 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/traffic_light_monitor.md
# traffic_light_monitor

Downstream checker for the traffic light controller. It samples the controller's 2-bit light code every clock and tracks the current phase and how many cycles it has lasted. It checks the Red→Green→Yellow→Red sequence and the per-phase dwell limits, and latches sticky fault flags for the supervisor. It sits between the controller output and the lamp-driver/supervisor logic and never drives the controller.

## Interface
- MIN_DWELL, 1: minimum legal cycles in a phase before it may advance.
- MAX_DWELL, 255: maximum legal cycles in a phase. Requires 1 ≤ MIN_DWELL ≤ MAX_DWELL ≤ 2^CNT_W−1.
- CNT_W, 8: dwell counter width.
- clock  in  1  sole clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- light_in  in  2  light code from controller: 0 Red, 1 Green, 2 Yellow, 3 illegal.
- err_clear  in  1  clears sticky flags and leaves FAULT.
- phase  out  2  confirmed current phase code.
- dwell  out  CNT_W  cycles `light_in` has equalled `phase` in the current phase.
- change  out  1  one-cycle pulse on each legal phase advance.
- fault  out  1  high while in FAULT.
- seq_err  out  1  sticky: skipped phase, or advance before MIN_DWELL.
- code_err  out  1  sticky: code 3 seen.
- timeout_err  out  1  sticky: phase held beyond MAX_DWELL.
- cycle_count  out  16  completed Yellow→Red advances, wraps at 2^16.

## Operation
- States: INIT, RED, GREEN, YELLOW, FAULT. `next(P)` is Red→Green, Green→Yellow, Yellow→Red.
- Reset:
  - state INIT.
  - `phase`=0, `dwell`=0, `cycle_count`=0.
  - `change`, `fault` and all error flags are 0.
- INIT:
  - `light_in`=Red: go to RED, `dwell`=1, no `change` pulse.
  - `light_in`=3: set `code_err`, go to FAULT.
  - Green or Yellow: ignored; stay in INIT with `dwell`=0.
- Phase state P. Checks are evaluated in this priority order:
  - `light_in`=3: set `code_err`, go to FAULT.
  - `light_in`=P and `dwell`<MAX_DWELL: `dwell`+1.
  - `light_in`=P and `dwell`=MAX_DWELL: set `timeout_err`, go to FAULT.
  - `light_in`=next(P) and `dwell`<MIN_DWELL: set `seq_err`, go to FAULT.
  - `light_in`=next(P) and `dwell`≥MIN_DWELL: legal advance. `phase`=next(P), `dwell`=1, `change`=1. If next(P) is Red, `cycle_count`+1.
  - Any other legal code (a skipped phase): set `seq_err`, go to FAULT.
- FAULT:
  - `phase` and `dwell` hold their values at fault entry.
  - Only the first error is recorded; later errors are ignored.
  - `err_clear`=1: next cycle all flags are 0, state INIT, `phase`=0, `dwell`=0. `cycle_count` is preserved.
- `err_clear` outside FAULT: no effect, since all flags are already 0.
- Simultaneous `err_clear` and a newly detected error in a non-FAULT state: the error wins and is latched.

## Timing
- All outputs are registered. Response latency is 1 cycle: a value on `light_in` at edge N is reflected in the outputs after edge N.
- `change` is high for exactly one cycle per advance. Back-to-back advances on consecutive cycles give `change` high on consecutive cycles.
- With MIN_DWELL=1 and a controller that advances every clock, `dwell` stays 1 and `change` is high every cycle after the first Red.
- An advance on the same cycle that `dwell`=MAX_DWELL is legal; no timeout is raised.
- Flags rise 1 cycle after the offending sample. `fault` rises in the same cycle as the flag.
- `reset` overrides everything, including mid-phase and FAULT, and clears `cycle_count`.

## Configuration
- TL_MON_CYCLE_CNT_EN defined: the `cycle_count` register and increment logic are built as described.
- TL_MON_CYCLE_CNT_EN undefined: the `cycle_count` port remains but is tied to 0 and no counter is synthesized. All other behaviour is identical.

## Structure
- Shared package `traffic_light_pkg` holds:
  - light codes RED=0, GREEN=1, YELLOW=2, ILLEGAL=3;
  - the monitor state enum;
  - a `next_light` function.
  
  The controller and the monitor both import it.
- One sub-module, `dwell_counter`: a CNT_W-bit counter with load-1, increment and clear controls, plus an `at_max` compare against MAX_DWELL.
- The FSM, error flags and cycle counter stay in the top module.

## Test plan
- Reset, then feed 0,1,2,0,1,2,0 one code per cycle (MIN=1) → `change` high on 6 consecutive cycles, no errors, `cycle_count`=2.
- MIN_DWELL=3: feed Red×2 then Green → `seq_err`=1 and `fault`=1 one cycle after Green; `phase`=0 and `dwell`=2 held.
- In RED, feed Yellow (skip Green) → `seq_err`=1; further code 3 samples leave `code_err`=0.
- MAX_DWELL=4: feed Red×5 → `timeout_err`=1 after the 5th sample; repeat with Red×4 then Green → legal advance, no error.
- Feed code 3 in GREEN → `code_err`=1. Pulse `err_clear` → next cycle all flags 0, state INIT, `phase`=0, `dwell`=0, `cycle_count` unchanged. A following Red is accepted with no `change` pulse.
- Assert `reset` mid-GREEN with `cycle_count`=5 → all outputs 0 the next cycle. With TL_MON_CYCLE_CNT_EN undefined, `cycle_count` is 0 throughout the first scenario.
